ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 177 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding SRAM fetch feeding a 2-entry {pc, inst} queue to ID.
// Optional macro IFU_ADEF_CHECK_EN adds misaligned-fetch detection and the if_to_id_adef port.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic        br_stall,
    input  logic [31:0] br_target,
    input  logic        i_id_ready,
    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_pc,
    output logic [31:0] if_to_id_inst
`ifdef IFU_ADEF_CHECK_EN
    ,
    output logic        if_to_id_adef
`endif
);

    typedef enum logic [0:0] {S_REQ, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             discard_q, discard_d;
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0][31:0] fifo_pc_q;
    logic [1:0][31:0] fifo_inst_q;

    logic             redirect;
    logic             pop;
    logic             push;
    logic             space;
    logic [1:0]       count_after_pop;
    logic [31:0]      push_pc;
    logic [31:0]      push_inst;

`ifdef IFU_ADEF_CHECK_EN
    logic [1:0]       fifo_adef_q;
    logic             push_adef;
    logic             misaligned;
    logic             adef_done_q, adef_done_d;

    assign misaligned    = fetch_pc_q[1:0] != 2'b00;
    assign if_to_id_adef = fifo_adef_q[rd_ptr_q];
`endif

    assign redirect        = br_taken & ~br_stall;
    assign if_to_id_valid  = (count_q != 2'd0) & ~redirect;
    assign if_to_id_pc     = fifo_pc_q[rd_ptr_q];
    assign if_to_id_inst   = fifo_inst_q[rd_ptr_q];
    assign pop             = if_to_id_valid & i_id_ready;
    assign count_after_pop = count_q - {1'b0, pop};
    assign space           = ~count_after_pop[1];
    assign inst_sram_addr  = fetch_pc_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        discard_d     = discard_q;
        inst_sram_req = 1'b0;
        push          = 1'b0;
        push_pc       = req_pc_q;
        push_inst     = inst_sram_rdata;
`ifdef IFU_ADEF_CHECK_EN
        push_adef     = 1'b0;
        adef_done_d   = adef_done_q;
`endif
        unique case (state_q)
            S_REQ: begin
`ifdef IFU_ADEF_CHECK_EN
                // A misaligned PC is reported once as a fault entry instead of being fetched.
                if (misaligned) begin
                    if (space && !redirect && !adef_done_q) begin
                        push        = 1'b1;
                        push_pc     = fetch_pc_q;
                        push_inst   = 32'h0;
                        push_adef   = 1'b1;
                        adef_done_d = 1'b1;
                    end
                end else
`endif
                begin
                    // rst gates req so nothing is requested while held in reset.
                    inst_sram_req = rst & space & ~redirect;
                    if (inst_sram_req && inst_sram_addr_ok) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    state_d   = S_REQ;
                    discard_d = 1'b0;
                    push      = ~discard_q & ~redirect;
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (redirect) begin
            fetch_pc_d = br_target;
`ifdef IFU_ADEF_CHECK_EN
            adef_done_d = 1'b0;
`endif
        end
    end

    always_comb begin
        if (redirect) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            discard_q  <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_pc_q   <= '0;
            fifo_inst_q <= '0;
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]   <= push_pc;
            fifo_inst_q[wr_ptr_q] <= push_inst;
        end
    end

`ifdef IFU_ADEF_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_adef_q <= 2'b00;
            adef_done_q <= 1'b0;
        end else begin
            adef_done_q <= adef_done_d;
            if (push) begin
                fifo_adef_q[wr_ptr_q] <= push_adef;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic checked against
// an instruction-stream reference model (consumed PCs are sequential from the last redirect).
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic        br_stall;
    logic [31:0] br_target;
    logic        i_id_ready;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;
`ifdef IFU_ADEF_CHECK_EN
    logic        if_to_id_adef;
`endif

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .br_taken          (br_taken),
        .br_stall          (br_stall),
        .br_target         (br_target),
        .i_id_ready        (i_id_ready),
        .if_to_id_valid    (if_to_id_valid),
        .if_to_id_pc       (if_to_id_pc),
        .if_to_id_inst     (if_to_id_inst)
`ifdef IFU_ADEF_CHECK_EN
        ,
        .if_to_id_adef     (if_to_id_adef)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Stimulus controls applied by cycle().
    logic        ctl_ready, ctl_taken, ctl_stall, ctl_aok;
    logic [31:0] ctl_target;
    int          ctl_lat;

    // Reference model: expected next consumed pc, expected next fetch address, entries in
    // flight since the last redirect, and a memory with one outstanding response.
    logic [31:0] exp_pc, exp_fetch, mem_addr;
    int          inflight, mem_cnt;
    logic        mem_busy;
    logic [31:0] outq[$];

    logic        smp_valid, smp_req, smp_acc, smp_adef;
    logic [31:0] smp_pc, smp_inst, smp_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic redir, cons, acc;
        @(negedge clk);
        i_id_ready        = ctl_ready;
        br_taken          = ctl_taken;
        br_stall          = ctl_stall;
        br_target         = ctl_target;
        inst_sram_addr_ok = ctl_aok;
        inst_sram_data_ok = mem_busy && (mem_cnt == 0);
        inst_sram_rdata   = inst_sram_data_ok ? inst_of(mem_addr) : $urandom;
        #1;
        redir = br_taken & ~br_stall;
        cons  = if_to_id_valid & i_id_ready;
        acc   = inst_sram_req & inst_sram_addr_ok;
        smp_valid = if_to_id_valid;
        smp_pc    = if_to_id_pc;
        smp_inst  = if_to_id_inst;
        smp_req   = inst_sram_req;
        smp_acc   = acc;
        smp_addr  = inst_sram_addr;
`ifdef IFU_ADEF_CHECK_EN
        smp_adef  = if_to_id_adef;
`else
        smp_adef  = 1'b0;
`endif
        if (mem_busy) chk("one_outstanding", 32'(inst_sram_req), 32'd0);
        if (redir) chk("valid_on_redirect", 32'(if_to_id_valid), 32'd0);
        if (cons) begin
            chk("out_pc", if_to_id_pc, exp_pc);
            chk("out_inst", if_to_id_inst, inst_of(exp_pc));
            outq.push_back(if_to_id_pc);
            exp_pc = exp_pc + 32'd4;
            inflight--;
        end
        if (acc) begin
            chk("fetch_addr", inst_sram_addr, exp_fetch);
            chk("fifo_room", 32'(inflight < 2), 32'd1);
            exp_fetch = exp_fetch + 32'd4;
            inflight++;
        end
        if (inst_sram_data_ok) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = inst_sram_addr;
            mem_cnt  = ctl_lat - 1;
        end
        if (redir) begin
            exp_pc    = br_target;
            exp_fetch = br_target;
            inflight  = 0;
        end
        @(posedge clk);
    endtask

    // Memory is reset together with the DUT, so any outstanding response is forgotten.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        i_id_ready = 1'b0; br_taken = 1'b0; br_stall = 1'b0; br_target = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
        #1;
        chk("rst_req", 32'(inst_sram_req), 32'd0);
        chk("rst_valid", 32'(if_to_id_valid), 32'd0);
        chk("rst_pc", if_to_id_pc, 32'd0);
        chk("rst_inst", if_to_id_inst, 32'd0);
        repeat (n) @(negedge clk);
        rst = 1'b1;
        exp_pc = RESET_PC; exp_fetch = RESET_PC; inflight = 0;
    endtask

    task automatic wait_output(input int budget, output logic got);
        int n0;
        n0  = outq.size();
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            got = outq.size() > n0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n0;
        logic got, found;
        logic [31:0] t;
        rst = 1'b0;
        ctl_ready = 1'b1; ctl_taken = 1'b0; ctl_stall = 1'b0; ctl_aok = 1'b1;
        ctl_target = '0; ctl_lat = 1;
        do_reset(3);

        // Sequential fetch from reset, fast memory, ID always ready.
        outq.delete();
        cycle();
        chk("first_req", 32'(smp_acc), 32'd1);
        chk("first_addr", smp_addr, RESET_PC);
        cycle();
        chk("push_cycle_valid", 32'(smp_valid), 32'd0);
        cycle();
        chk("latency_valid", 32'(smp_valid), 32'd1);
        repeat (5) cycle();
        chk("seq_count", 32'(outq.size() >= 3), 32'd1);
        chk("seq0", (outq.size() > 0) ? outq[0] : 32'hx, 32'h1c000000);
        chk("seq1", (outq.size() > 1) ? outq[1] : 32'hx, 32'h1c000004);
        chk("seq2", (outq.size() > 2) ? outq[2] : 32'hx, 32'h1c000008);

        // ID stall: queue fills to two and requests stop, then drains in order.
        ctl_ready = 1'b0;
        repeat (6) cycle();
        chk("stall_req_off", 32'(smp_req), 32'd0);
        chk("stall_valid", 32'(smp_valid), 32'd1);
        chk("stall_buffered", 32'(inflight), 32'd2);
        chk("stall_no_outstanding", 32'(mem_busy), 32'd0);
        ctl_ready = 1'b1;
        n0 = outq.size();
        cycle();
        chk("drain0_valid", 32'(smp_valid), 32'd1);
        cycle();
        chk("drain1_valid", 32'(smp_valid), 32'd1);
        repeat (4) cycle();
        chk("drain_count", 32'(outq.size() - n0 >= 3), 32'd1);

        // Redirect while waiting; the late response must be dropped.
        ctl_lat = 4;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = smp_acc;
        end
        chk("wait_accept", 32'(found), 32'd1);
        ctl_taken = 1'b1; ctl_target = 32'h1c000100;
        cycle();
        ctl_taken = 1'b0; ctl_lat = 1;
        n0 = outq.size();
        wait_output(20, got);
        chk("redir_got_output", 32'(got), 32'd1);
        chk("redir_first_pc", got ? outq[n0] : 32'hx, 32'h1c000100);

        // Unresolved branch: no flush, stream continues.
        ctl_taken = 1'b1; ctl_stall = 1'b1; ctl_target = 32'h0bad0000;
        n0 = outq.size();
        repeat (4) cycle();
        chk("br_stall_no_flush", 32'(outq.size() - n0 >= 2), 32'd1);
        ctl_taken = 1'b0; ctl_stall = 1'b0;
        repeat (4) cycle();

        // Redirect coinciding with data_ok and a would-be pop.
        ctl_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_busy && mem_cnt == 0 && inflight == 2) found = 1'b1;
            else cycle();
        end
        chk("flush_setup", 32'(found), 32'd1);
        ctl_ready = 1'b1; ctl_taken = 1'b1; ctl_target = 32'h1c000300;
        cycle();
        chk("flush_same_cycle_valid", 32'(smp_valid), 32'd0);
        ctl_ready = 1'b0; ctl_taken = 1'b0;
        cycle();
        chk("flush_next_valid", 32'(smp_valid), 32'd0);
        chk("flush_fetch_pc", smp_addr, 32'h1c000300);
        ctl_ready = 1'b1;
        repeat (6) cycle();

        // Reset in the middle of an outstanding fetch.
        ctl_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = smp_acc;
        end
        chk("mid_accept", 32'(found), 32'd1);
        cycle();
        do_reset(2);
        ctl_lat = 1;
        n0 = outq.size();
        wait_output(20, got);
        chk("post_reset_output", 32'(got), 32'd1);
        chk("post_reset_pc", got ? outq[n0] : 32'hx, RESET_PC);

`ifdef IFU_ADEF_CHECK_EN
        // Misaligned redirect target: no request, one fault entry.
        ctl_ready = 1'b0;
        for (int i = 0; i < 10 && mem_busy; i++) cycle();
        ctl_taken = 1'b1; ctl_target = 32'h1c000102;
        cycle();
        ctl_taken = 1'b0;
        repeat (4) begin
            cycle();
            chk("adef_no_req", 32'(smp_req), 32'd0);
        end
        chk("adef_valid", 32'(smp_valid), 32'd1);
        chk("adef_pc", smp_pc, 32'h1c000102);
        chk("adef_inst", smp_inst, 32'd0);
        chk("adef_flag", 32'(smp_adef), 32'd1);
        ctl_taken = 1'b1; ctl_target = 32'h1c000400;
        cycle();
        ctl_taken = 1'b0; ctl_ready = 1'b1;
        repeat (6) cycle();
`endif

        // Randomized traffic against the stream model.
        for (int i = 0; i < 3000; i++) begin
            ctl_ready = ($urandom_range(3) != 0);
            ctl_aok   = ($urandom_range(9) < 7);
            ctl_lat   = int'($urandom_range(3, 1));
            ctl_taken = ($urandom_range(15) == 0);
            ctl_stall = ($urandom_range(3) == 0);
            t = $urandom;
            ctl_target = {t[31:2], 2'b00};
            cycle();
        end

        // Quiet tail: the stream must keep flowing.
        ctl_ready = 1'b1; ctl_aok = 1'b1; ctl_taken = 1'b0; ctl_stall = 1'b0; ctl_lat = 1;
        n0 = outq.size();
        repeat (12) cycle();
        chk("tail_progress", 32'(outq.size() - n0 >= 4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
